// File: rtl/conv_ctrl_axil_mc.sv
// AXI4-Lite control/status slave for the KxK convolution filter: CTRL/STATUS/counters plus
// shadowed coefficients. Build macro CONV_CTRL_CYCLE_CNT_EN adds the RUN cycle counter at 0x0C.
module conv_ctrl_axil_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned K          = 3,
  parameter int unsigned COEF_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       s_axi_control_awaddr,
  input  logic                        s_axi_control_awvalid,
  output logic                        s_axi_control_awready,
  input  logic [DATA_WIDTH-1:0]       s_axi_control_wdata,
  input  logic [DATA_WIDTH/8-1:0]     s_axi_control_wstrb,
  input  logic                        s_axi_control_wvalid,
  output logic                        s_axi_control_wready,
  output logic [1:0]                  s_axi_control_bresp,
  output logic                        s_axi_control_bvalid,
  input  logic                        s_axi_control_bready,
  input  logic [ADDR_WIDTH-1:0]       s_axi_control_araddr,
  input  logic                        s_axi_control_arvalid,
  output logic                        s_axi_control_arready,
  output logic [DATA_WIDTH-1:0]       s_axi_control_rdata,
  output logic [1:0]                  s_axi_control_rresp,
  output logic                        s_axi_control_rvalid,
  input  logic                        s_axi_control_rready,
  input  logic                        tlast,
  output logic                        start,
  output logic                        run,
  output logic                        irq,
  output logic [K*K*COEF_WIDTH-1:0]   filter_weights
);

  localparam int unsigned NumCoef  = K * K;
  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned WgtW     = NumCoef * COEF_WIDTH;
  localparam int unsigned CoefBase = 4;
  localparam int unsigned RegEnd   = CoefBase + NumCoef;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Write channel state
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-3:0] aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;

  // Read channel state
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Register file and FSM
  logic [1:0]            state_q, state_d;
  logic                  start_q, start_d;
  logic                  ctrl_irq_en_q, ctrl_irq_en_d;
  logic                  ctrl_auto_q, ctrl_auto_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [WgtW-1:0]       coef_q, coef_d;
  logic [WgtW-1:0]       shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] cycle_cnt;

  logic                  aw_fire, w_fire, wr_go, b_done, ar_fire, r_done;
  logic [31:0]           wr_sel, rd_sel;
  logic                  wr_mapped;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  start_req, done_set, done_clr, reload;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_hit;
  logic                  unused_bits;

  assign aw_fire = s_axi_control_awvalid & ~aw_held_q;
  assign w_fire  = s_axi_control_wvalid & ~w_held_q;
  // Commit fires once, in the cycle after both beats are held, and raises bvalid.
  assign wr_go   = aw_held_q & w_held_q & ~bvalid_q;
  assign b_done  = bvalid_q & s_axi_control_bready;
  assign ar_fire = s_axi_control_arvalid & ~rvalid_q;
  assign r_done  = rvalid_q & s_axi_control_rready;

  assign wr_sel    = 32'(aw_idx_q);
  assign rd_sel    = 32'(s_axi_control_araddr[ADDR_WIDTH-1:2]);
  assign wr_mapped = (wr_sel < RegEnd);

  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < StrbW; b++) begin
      wr_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_control_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_control_wdata;
      wstrb_d  = s_axi_control_wstrb;
    end
    if (wr_go) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_mapped ? RespOkay : RespSlverr;
    end
    if (b_done) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_comb begin
    ctrl_irq_en_d = ctrl_irq_en_q;
    ctrl_auto_d   = ctrl_auto_q;
    coef_d        = coef_q;
    shadow_d      = shadow_q;
    state_d       = state_q;
    done_d        = done_q;
    frame_cnt_d   = frame_cnt_q;
    start_req     = 1'b0;
    done_set      = 1'b0;
    done_clr      = 1'b0;
    reload        = 1'b0;

    if (wr_go) begin
      if (wr_sel == 32'd0) begin
        if (wr_mask[1]) ctrl_irq_en_d = wdata_q[1];
        if (wr_mask[2]) ctrl_auto_d = wdata_q[2];
        start_req = wr_mask[0] & wdata_q[0];
      end
      if (wr_sel == 32'd1) begin
        done_clr = wr_mask[2] & wdata_q[2];
      end
      for (int unsigned i = 0; i < NumCoef; i++) begin
        if (wr_sel == CoefBase + i) begin
          coef_d[i*COEF_WIDTH +: COEF_WIDTH] =
            (coef_q[i*COEF_WIDTH +: COEF_WIDTH] & ~wr_mask[COEF_WIDTH-1:0]) |
            (wdata_q[COEF_WIDTH-1:0] & wr_mask[COEF_WIDTH-1:0]);
        end
      end
    end

    // A start write outside IDLE is simply dropped; the bit never reads back as 1.
    case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StRun;
          reload  = 1'b1;
        end
      end
      StRun: begin
        if (tlast) begin
          state_d     = StDone;
          done_set    = 1'b1;
          frame_cnt_d = frame_cnt_q + DATA_WIDTH'(1);
        end
      end
      StDone: begin
        if (ctrl_auto_q) begin
          state_d = StRun;
          reload  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Shadow samples the pre-write coefficients, so a same-cycle COEF write waits a frame.
    if (reload) shadow_d = coef_q;
    if (done_set) begin
      done_d = 1'b1;
    end else if (done_clr) begin
      done_d = 1'b0;
    end
  end

  assign start_d = reload;

`ifdef CONV_CTRL_CYCLE_CNT_EN
  logic [DATA_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (reload) begin
      cycle_cnt_d = '0;
    end else if ((state_q == StRun) && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = '0;
`endif

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b1;
    case (rd_sel)
      32'd0: rd_word = DATA_WIDTH'({ctrl_auto_q, ctrl_irq_en_q, 1'b0});
      32'd1: rd_word = DATA_WIDTH'({done_q, state_q});
      32'd2: rd_word = frame_cnt_q;
      32'd3: rd_word = cycle_cnt;
      default: begin
        rd_hit = 1'b0;
        for (int unsigned i = 0; i < NumCoef; i++) begin
          if (rd_sel == CoefBase + i) begin
            rd_hit  = 1'b1;
            rd_word = DATA_WIDTH'(coef_q[i*COEF_WIDTH +: COEF_WIDTH]);
          end
        end
      end
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_hit ? RespOkay : RespSlverr;
    end
    if (r_done) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RespOkay;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rvalid_q      <= 1'b0;
      rresp_q       <= RespOkay;
      rdata_q       <= '0;
      state_q       <= StIdle;
      start_q       <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      ctrl_auto_q   <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= '0;
      coef_q        <= '0;
      shadow_q      <= '0;
    end else begin
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      aw_idx_q      <= aw_idx_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      state_q       <= state_d;
      start_q       <= start_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      ctrl_auto_q   <= ctrl_auto_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
      coef_q        <= coef_d;
      shadow_q      <= shadow_d;
    end
  end

  assign s_axi_control_awready = ~aw_held_q;
  assign s_axi_control_wready  = ~w_held_q;
  assign s_axi_control_bvalid  = bvalid_q;
  assign s_axi_control_bresp   = bresp_q;
  assign s_axi_control_arready = ~rvalid_q;
  assign s_axi_control_rvalid  = rvalid_q;
  assign s_axi_control_rdata   = rdata_q;
  assign s_axi_control_rresp   = rresp_q;
  assign start                 = start_q;
  assign run                   = (state_q == StRun);
  assign irq                   = done_q & ctrl_irq_en_q;
  assign filter_weights        = shadow_q;

  // Byte-offset bits and high data/strobe bits beyond the mapped fields carry no state.
  assign unused_bits = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0], wdata_q, wr_mask};

endmodule

// File: tb/tb_conv_ctrl_axil_mc.sv
// Self-checking bench for conv_ctrl_axil_mc: register vector table plus hand-written sequences
// for handshakes, FSM, interrupt, auto-restart, cycle counter and mid-transaction reset.
module tb_conv_ctrl_axil_mc;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int KK = 3;
  localparam int CW = 8;
  localparam int FW = KK * KK * CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic            tlast = 1'b0;
  logic            start;
  logic            run;
  logic            irq;
  logic [FW-1:0]   filter_weights;

  conv_ctrl_axil_mc #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .K(KK),
    .COEF_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_control_awaddr(awaddr),
    .s_axi_control_awvalid(awvalid),
    .s_axi_control_awready(awready),
    .s_axi_control_wdata(wdata),
    .s_axi_control_wstrb(wstrb),
    .s_axi_control_wvalid(wvalid),
    .s_axi_control_wready(wready),
    .s_axi_control_bresp(bresp),
    .s_axi_control_bvalid(bvalid),
    .s_axi_control_bready(bready),
    .s_axi_control_araddr(araddr),
    .s_axi_control_arvalid(arvalid),
    .s_axi_control_arready(arready),
    .s_axi_control_rdata(rdata),
    .s_axi_control_rresp(rresp),
    .s_axi_control_rvalid(rvalid),
    .s_axi_control_rready(rready),
    .tlast(tlast),
    .start(start),
    .run(run),
    .irq(irq),
    .filter_weights(filter_weights)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]    coef_m[KK*KK];
  logic [FW-1:0] exp_fw;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic snap_fw();
    for (int i = 0; i < KK * KK; i++) exp_fw[i*CW +: CW] = coef_m[i];
  endtask

  task automatic add_vec(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                         input logic [1:0] br, input logic [DW-1:0] rd, input logic [1:0] rr,
                         input string nm);
    vec_t v;
    v.addr = a; v.wdata = d; v.wstrb = s; v.bresp = br; v.rdata = rd; v.rresp = rr; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input logic [1:0] er, input string nm);
    bit aw_ok, w_ok, aw_acc, w_acc, got;
    bq.push_back(er);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0;
    for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick(1);
      if (aw_acc) begin aw_ok = 1'b1; awvalid = 1'b0; end
      if (w_acc) begin w_ok = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) timeout({nm, " aw/w accept"});
    bready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bvalid) begin
        got = 1'b1;
        check({nm, " bresp"}, 128'(bresp), 128'(bq.pop_front()));
      end
      tick(1);
    end
    bready = 1'b0;
    if (!got) begin
      timeout({nm, " bvalid"});
      bq.delete();
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er,
                          input string nm);
    bit acc, ok, got;
    rexp_t e;
    e.d = ed; e.r = er;
    rq.push_back(e);
    araddr = a; arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      acc = arvalid && arready;
      tick(1);
      if (acc) begin ok = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    if (!ok) timeout({nm, " ar accept"});
    rready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (rvalid) begin
        got = 1'b1;
        e = rq.pop_front();
        check({nm, " rdata"}, 128'(rdata), 128'(e.d));
        check({nm, " rresp"}, 128'(rresp), 128'(e.r));
      end
      tick(1);
    end
    rready = 1'b0;
    if (!got) begin
      timeout({nm, " rvalid"});
      rq.delete();
    end
  endtask

  task automatic pulse_tlast();
    tlast = 1'b1;
    tick(1);
    tlast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, hold;
    bit got;

    // Register table: write then read back
    for (int i = 0; i < KK * KK; i++) begin
      add_vec(AW'(16 + 4 * i), DW'(i + 1), 4'hF, 2'b00, DW'(i + 1), 2'b00, $sformatf("coef%0d", i));
    end
    add_vec(6'h18, 32'h0000_FF00, 4'h2, 2'b00, 32'h3, 2'b00, "coef2 high byte");
    add_vec(6'h10, 32'hAABB_CCDD, 4'h1, 2'b00, 32'hDD, 2'b00, "coef0 strb1");
    add_vec(6'h10, 32'h0000_0001, 4'hF, 2'b00, 32'h1, 2'b00, "coef0 restore");
    add_vec(6'h3C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0, 2'b10, "unmapped 3c");
    add_vec(6'h34, 32'h1234_5678, 4'hF, 2'b10, 32'h0, 2'b10, "unmapped 34");
    add_vec(6'h08, 32'h0000_0055, 4'hF, 2'b00, 32'h0, 2'b00, "frame_cnt ro");
    add_vec(6'h0C, 32'h0000_0055, 4'hF, 2'b00, 32'h0, 2'b00, "cycle_cnt ro");
    add_vec(6'h04, 32'h0000_0003, 4'hF, 2'b00, 32'h0, 2'b00, "status ro");
    add_vec(6'h00, 32'h0000_0006, 4'hF, 2'b00, 32'h6, 2'b00, "ctrl irq/auto");
    add_vec(6'h00, 32'h0000_0006, 4'h0, 2'b00, 32'h6, 2'b00, "ctrl no strobe");
    add_vec(6'h00, 32'h0000_0000, 4'hF, 2'b00, 32'h0, 2'b00, "ctrl clear");

    // Reset values
    tick(3);
    check("rst awready", 128'(awready), 128'(1));
    check("rst wready", 128'(wready), 128'(1));
    check("rst arready", 128'(arready), 128'(1));
    check("rst bvalid", 128'(bvalid), 128'(0));
    check("rst rvalid", 128'(rvalid), 128'(0));
    check("rst start", 128'(start), 128'(0));
    check("rst run", 128'(run), 128'(0));
    check("rst irq", 128'(irq), 128'(0));
    check("rst bresp/rresp", 128'({bresp, rresp}), 128'(0));
    check("rst rdata", 128'(rdata), 128'(0));
    check("rst filter_weights", 128'(filter_weights), 128'(0));
    rst_n = 1'b1;
    tick(1);

    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].bresp, {vecs[i].name, " wr"});
      axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp, {vecs[i].name, " rd"});
    end
    for (int i = 0; i < KK * KK; i++) coef_m[i] = 8'(i + 1);

    // Start a frame
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl start");
    tick(2);
    snap_fw();
    check("start pulse count 1", 128'(start_cnt), 128'(1));
    check("run after start", 128'(run), 128'(1));
    check("filter_weights 9..1", 128'(filter_weights), 128'(exp_fw));
    axi_read(6'h04, 32'h1, 2'b00, "status running");

    // AW three cycles ahead of W, then B held off for 4 cycles
    awaddr = 6'h14; awvalid = 1'b1;
    tick(1);
    awvalid = 1'b0;
    tick(2);
    check("aw held awready", 128'(awready), 128'(0));
    check("aw held wready", 128'(wready), 128'(1));
    check("aw held no bvalid", 128'(bvalid), 128'(0));
    wdata = 32'h42; wstrb = 4'hF; wvalid = 1'b1;
    tick(1);
    wvalid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (bvalid) got = 1'b1;
      else tick(1);
    end
    if (!got) timeout("split write bvalid");
    hold = 0;
    for (int n = 0; n < 4; n++) begin
      tick(1);
      if (bvalid) hold++;
    end
    check("bvalid held 4 cycles", 128'(hold), 128'(4));
    check("split write bresp", 128'(bresp), 128'(0));
    bready = 1'b1;
    tick(1);
    bready = 1'b0;
    check("bvalid dropped", 128'(bvalid), 128'(0));
    check("awready back", 128'(awready), 128'(1));
    axi_read(6'h14, 32'h42, 2'b00, "coef1 split write");
    check("shadow stable in run", 128'(filter_weights), 128'(exp_fw));
    coef_m[1] = 8'h42;

    // Done with interrupt
    axi_write(6'h00, 32'h2, 4'hF, 2'b00, "ctrl irq_en");
    pulse_tlast();
    tick(3);
    check("idle after done", 128'(run), 128'(0));
    axi_read(6'h04, 32'h4, 2'b00, "status done");
    check("irq set", 128'(irq), 128'(1));
    axi_read(6'h08, 32'h1, 2'b00, "frame_cnt 1");
    pulse_tlast();
    tick(2);
    axi_read(6'h08, 32'h1, 2'b00, "tlast ignored idle");
    axi_write(6'h04, 32'h4, 4'hF, 2'b00, "status w1c");
    check("irq cleared", 128'(irq), 128'(0));
    axi_read(6'h04, 32'h0, 2'b00, "status cleared");

    // Auto-restart with coefficient change during RUN
    axi_write(6'h00, 32'h5, 4'hF, 2'b00, "ctrl start auto");
    tick(2);
    snap_fw();
    check("start pulse count 2", 128'(start_cnt), 128'(2));
    check("shadow reload", 128'(filter_weights), 128'(exp_fw));
    axi_write(6'h10, 32'h7F, 4'hF, 2'b00, "coef0 7f in run");
    coef_m[0] = 8'h7F;
    check("shadow holds old", 128'(filter_weights), 128'(exp_fw));
    t0 = cyc;
    pulse_tlast();
    tick(3);
    snap_fw();
    check("restart pulse timing", 128'(last_start_cyc), 128'(t0 + 2));
    check("start pulse count 3", 128'(start_cnt), 128'(3));
    check("fw[7:0] 7f", 128'(filter_weights[7:0]), 128'(8'h7F));
    check("shadow after restart", 128'(filter_weights), 128'(exp_fw));
    check("running again", 128'(run), 128'(1));
    axi_write(6'h00, 32'h0, 4'hF, 2'b00, "ctrl auto off");
    pulse_tlast();
    tick(3);
    check("stopped", 128'(run), 128'(0));
    axi_read(6'h04, 32'h4, 2'b00, "status done 2");
    check("irq gated off", 128'(irq), 128'(0));
    axi_read(6'h08, 32'h3, 2'b00, "frame_cnt 3");

    // 100-cycle RUN for the cycle counter
    axi_write(6'h04, 32'h4, 4'hF, 2'b00, "status w1c 2");
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl start 100");
    s = last_start_cyc;
    for (int n = 0; n < 200 && cyc < s + 99; n++) tick(1);
    pulse_tlast();
    tick(3);
`ifdef CONV_CTRL_CYCLE_CNT_EN
    axi_read(6'h0C, 32'd100, 2'b00, "cycle_cnt 100");
`else
    axi_read(6'h0C, 32'd0, 2'b00, "cycle_cnt absent");
`endif
    axi_read(6'h08, 32'h4, 2'b00, "frame_cnt 4");

    // Reset in the middle of a write
    axi_write(6'h00, 32'h1, 4'hF, 2'b00, "ctrl start pre-reset");
    awaddr = 6'h10; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check("mid rst bvalid", 128'(bvalid), 128'(0));
    check("mid rst awready", 128'(awready), 128'(1));
    check("mid rst wready", 128'(wready), 128'(1));
    check("mid rst run", 128'(run), 128'(0));
    check("mid rst filter_weights", 128'(filter_weights), 128'(0));
    rst_n = 1'b1;
    tick(1);
    axi_read(6'h10, 32'h0, 2'b00, "coef0 after reset");
    axi_read(6'h08, 32'h0, 2'b00, "frame_cnt after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_ctrl_axil_mc.md
Name: conv_ctrl_axil_mc

Overview:
Parametrised AXI4-Lite control/status slave for the 2D convolution filter. It generalises the fixed 3x3 control block to a configurable KxK kernel of COEF_WIDTH-bit coefficients. It adds byte strobes, independent AW/W acceptance, SLVERR on unmapped addresses, a sticky done flag with interrupt, and auto-restart. Coefficients are shadowed so the datapath sees a stable kernel for a whole frame.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width; legal values are 32 and 64.
ADDR_WIDTH, 6, byte-address width; must cover 0x10 + 4*K*K.
K, 3, kernel dimension; the block holds K*K coefficients.
COEF_WIDTH, 8, bits per coefficient; must be <= DATA_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s_axi_control_awaddr  in  ADDR_WIDTH  write address (byte)
s_axi_control_awvalid  in  1  write-address valid
s_axi_control_awready  out  1  write-address ready
s_axi_control_wdata  in  DATA_WIDTH  write data
s_axi_control_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_control_wvalid  in  1  write-data valid
s_axi_control_wready  out  1  write-data ready
s_axi_control_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axi_control_bvalid  out  1  write-response valid
s_axi_control_bready  in  1  write-response ready
s_axi_control_araddr  in  ADDR_WIDTH  read address
s_axi_control_arvalid  in  1  read-address valid
s_axi_control_arready  out  1  read-address ready
s_axi_control_rdata  out  DATA_WIDTH  read data
s_axi_control_rresp  out  2  read response: 00 OKAY, 10 SLVERR
s_axi_control_rvalid  out  1  read-data valid
s_axi_control_rready  in  1  read-data ready
tlast  in  1  last pixel of the frame from the datapath
start  out  1  one-cycle pulse when a frame begins
run  out  1  high while the FSM is in RUN
irq  out  1  level interrupt = done_sticky & CTRL.irq_en
filter_weights  out  K*K*COEF_WIDTH  shadowed coefficients; coefficient i sits at bits [i*COEF_WIDTH +: COEF_WIDTH]

Behaviour:
- Register decode uses byte address bits [ADDR_WIDTH-1:2].
- Register map:
  - 0x00 CTRL (RW): bit0 start (self-clearing), bit1 irq_en, bit2 auto_restart.
  - 0x04 STATUS: bits[1:0] state (RO; 0 IDLE, 1 RUN, 2 DONE), bit2 done_sticky (W1C).
  - 0x08 FRAME_CNT (RO): frames completed, wraps at 2^DATA_WIDTH.
  - 0x0C CYCLE_CNT (RO): see Optional Feature.
  - 0x10+4*i COEF[i] (RW), i = 0..K*K-1; bits above COEF_WIDTH read as 0.
- Any other address is unmapped. Unmapped write: no state change, bresp = SLVERR. Unmapped read: rdata = 0, rresp = SLVERR.
- Reset values: all registers 0, shadow 0, FSM IDLE. Outputs: awready = wready = arready = 1; bvalid = rvalid = start = run = irq = 0; bresp = rresp = 00; rdata = 0; filter_weights = 0.
- Write channel:
  - AW and W are accepted independently. Each ready drops once its beat is latched.
  - The register update happens in the cycle after both beats are held.
  - bvalid asserts in that same cycle and holds until bready. awready and wready re-assert the cycle after the B handshake.
  - wstrb masks per byte; RO bits ignore writes.
  - A write of 1 to CTRL.start is honoured only in IDLE. In any other state the bit is dropped, and the response is still OKAY.
- Read channel:
  - arready is high when no read is pending.
  - On the AR handshake, rdata and rresp are registered. rvalid asserts the next cycle and holds until rready; arready re-asserts the cycle after.
  - rdata stays stable while rvalid is high.
- Status FSM:
  - IDLE -> RUN when CTRL.start is written 1. In that cycle: start pulses 1 cycle, COEF[] is copied into the shadow, and CTRL.start clears.
  - RUN -> DONE on tlast. On that transition: done_sticky is set and FRAME_CNT increments. tlast in any other state is ignored.
  - DONE lasts exactly 1 cycle. If auto_restart = 1 it goes to RUN, with the start pulse and shadow reload; otherwise it goes to IDLE.
  - run = (state == RUN).
- Simultaneous events:
  - A W1C of done_sticky in the same cycle as a set: the set wins.
  - A COEF write in the same cycle as a start pulse: the shadow takes the pre-write value.
- COEF writes during RUN update the register only. filter_weights changes only at a start pulse.
- Reset mid-transaction: pending AW/W/B/R are dropped and all outputs return to reset values.

Optional Feature:
CONV_CTRL_CYCLE_CNT_EN
- Defined: CYCLE_CNT is cleared on the start pulse and increments every cycle in RUN. It saturates at all-ones and holds its value in IDLE/DONE.
- Undefined: no counter logic is built; address 0x0C reads 0 with OKAY.

Test Plan:
- Write 0x10..0x30 with 1..9 (wstrb = 0xF), then CTRL = 0x1 -> start pulses once. filter_weights = {9,8,...,1} (8-bit each). Reading STATUS while running returns 0x1.
- AW is presented 3 cycles before W, then W is presented alone -> exactly one update. bvalid is held with bready low for 4 cycles, then completes with bresp = 00.
- Write to 0x3C and read 0x3C -> bresp = 10 and no register changes; rdata = 0 with rresp = 10.
- irq_en = 1, then pulse tlast in RUN -> STATUS = 0x4 (IDLE with done) and irq = 1, FRAME_CNT = 1. Writing STATUS = 0x4 clears irq.
- auto_restart = 1 with COEF[0] changed to 0x7F during RUN, then tlast -> a second start pulse 2 cycles after tlast, and filter_weights[7:0] = 0x7F.
- Write COEF[0] = 0xAABBCCDD with wstrb = 0x1 -> reads back 0xDD. With CONV_CTRL_CYCLE_CNT_EN defined and a 100-cycle RUN, CYCLE_CNT = 100.
